// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add multiplier sequencer driving the shared ALU
module alu_mul_seq #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     Start,
   input  logic                     Flush,
   input  logic [DATA_WIDTH-1:0]    OpA,
   input  logic [DATA_WIDTH-1:0]    OpB,
   output logic                     Busy,
   output logic                     Done,
   output logic [DATA_WIDTH-1:0]    Product,
   output logic [DATA_WIDTH-1:0]    AluSrcA,
   output logic [DATA_WIDTH-1:0]    AluSrcB,
   output logic [OPCODE_LENGTH-1:0] AluOperation,
   input  logic [DATA_WIDTH-1:0]    AluResult
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLLI = OPCODE_LENGTH'(4'b1101);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_SHL,
      S_DONE
   } state_t;

   state_t                state;
   state_t                next_state;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [CW-1:0]         cnt;
   logic [DATA_WIDTH-1:0] mplier_shr;
   logic                  last_pair;

   assign mplier_shr = mplier >> 1;
   // Stop once no multiplier bits remain, or after the final bit position.
   assign last_pair  = (mplier_shr == '0) || (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      Busy         = 1'b0;
      Done         = 1'b0;
      AluOperation = OP_ADD;
      AluSrcA      = '0;
      AluSrcB      = '0;
      case (state)
         S_IDLE: begin
            if (Start && !Flush) next_state = S_ACC;
         end
         S_ACC: begin
            Busy       = 1'b1;
            AluSrcA    = acc;
            AluSrcB    = mplier[0] ? mcand : '0;
            next_state = Flush ? S_IDLE : S_SHL;
         end
         S_SHL: begin
            Busy         = 1'b1;
            AluOperation = OP_SLLI;
            AluSrcA      = mcand;
            AluSrcB      = DATA_WIDTH'(1);
            if (Flush)          next_state = S_IDLE;
            else if (last_pair) next_state = S_DONE;
            else                next_state = S_ACC;
         end
         S_DONE: begin
            Busy       = 1'b1;
            // A flush landing on the DONE cycle suppresses the pulse.
            Done       = !Flush;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
         Product <= '0;
      end else if (!Flush) begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  acc    <= '0;
                  mcand  <= OpA;
                  mplier <= OpB;
                  cnt    <= '0;
               end
            end
            S_ACC: acc <= AluResult;
            S_SHL: begin
               mcand  <= AluResult;
               mplier <= mplier_shr;
               cnt    <= cnt + CW'(1);
               if (last_pair) Product <= acc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle integer multiplier controller that sequences the shared 32-bit ALU to compute the low DATA_WIDTH bits of OpA×OpB by shift-and-add. It sits beside the EX stage. While Busy is high it owns the ALU's SrcA, SrcB and Operation inputs, issuing exactly one ADD or SLLI per cycle. It captures each ALU result, so no hardware multiplier is needed.

## Interface
Parameters:
- DATA_WIDTH, 32, operand, product and ALU data width
- OPCODE_LENGTH, 4, ALU Operation code width

Ports:
- clk  input  1  rising-edge clock; single clock domain
- reset  input  1  asynchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- Flush  input  1  synchronous abort of an operation in progress
- OpA  input  DATA_WIDTH  multiplicand, sampled with Start
- OpB  input  DATA_WIDTH  multiplier, sampled with Start
- Busy  output  1  high in ACC, SHL and DONE
- Done  output  1  one-cycle pulse; Product is valid while Done is high
- Product  output  DATA_WIDTH  (OpA*OpB) mod 2^DATA_WIDTH; holds until the next DONE
- AluSrcA  output  DATA_WIDTH  drives ALU SrcA
- AluSrcB  output  DATA_WIDTH  drives ALU SrcB
- AluOperation  output  OPCODE_LENGTH  drives ALU Operation
- AluResult  input  DATA_WIDTH  combinational result from the ALU

## Operation
- Internal registers: acc, mcand and mplier (each DATA_WIDTH), cnt ($clog2(DATA_WIDTH) bits), Product, and the state.
- States: IDLE, ACC, SHL, DONE.
- IDLE
  - Drives AluOperation=4'b0010, AluSrcA=0, AluSrcB=0.
  - On Start=1 and Flush=0: acc<=0, mcand<=OpA, mplier<=OpB, cnt<=0, then go to ACC.
- ACC
  - Drives AluOperation=4'b0010 (ADD), AluSrcA=acc, AluSrcB = mplier[0] ? mcand : 0.
  - acc<=AluResult, then go to SHL.
- SHL
  - Drives AluOperation=4'b1101 (SLLI), AluSrcA=mcand, AluSrcB=1.
  - Updates: mcand<=AluResult; mplier<=mplier>>1 (logical, done locally); cnt<=cnt+1.
  - Go to DONE with Product<=acc when (mplier>>1)==0 or cnt==DATA_WIDTH-1.
  - Otherwise go back to ACC.
- DONE
  - Done=1 for exactly one cycle, ALU drives as in IDLE, then go to IDLE.
- Signedness: the low DATA_WIDTH bits are identical for signed and unsigned operands, so no sign handling is needed.
- All arithmetic wraps modulo 2^DATA_WIDTH.
- Flush=1 in ACC, SHL or DONE: go to IDLE next cycle. Done is not pulsed and Product is left unchanged.
- Start while not in IDLE: ignored; it is not queued.
- Start and Flush together in IDLE: Flush wins and the block stays in IDLE.
- reset (asynchronous, any state)
  - State goes to IDLE and every register clears to 0.
  - Outputs during reset: Busy=0, Done=0, Product=0, AluSrcA=0, AluSrcB=0, AluOperation=4'b0010.

## Timing
- Start is sampled at edge E0. Let k be the index of the highest set bit of OpB, with k=0 when OpB is 0 or 1.
- Phases after E0:
  - k+1 ACC/SHL pairs occupy 2(k+1) cycles.
  - DONE follows, so Done is high in the cycle after edge E0+2(k+1).
  - Latency from Start to Done is 2k+3 cycles: minimum 3, maximum 2·DATA_WIDTH+1 = 65.
- Busy rises in the cycle after E0 and falls in the cycle after Done.
- Back-to-back: the earliest next Start is the cycle after Done (IDLE).
- ALU outputs are combinational from the state and registers. AluResult is consumed in the same cycle it is produced, so the path from ALU out back to the registers is a single-cycle path.
- Product changes only at the SHL→DONE edge, or on reset.

## Test plan
- OpA=6, OpB=7 -> Done 7 cycles after Start; Product=42. AluOperation alternates 0010/1101 for 3 pairs.
- OpA=0xFFFFFFFF, OpB=0xFFFFFFFF -> Done after 65 cycles; Product=0x00000001. cnt terminates at 31.
- OpA=0x12345678, OpB=0 -> Done after 3 cycles; Product=0. A second Start pulsed while Busy is ignored.
- OpA=3, OpB=0x80000000 -> Product=0x80000000 after 65 cycles. A signed check, OpA=-3 (0xFFFFFFFD) with OpB=5, gives Product=0xFFFFFFF1.
- Start 6×7 to completion (Product=42), then Start 9×9 and assert Flush in the 3rd busy cycle -> IDLE next cycle, no Done, Product stays 42.
- Assert reset asynchronously mid-operation (between edges) -> Busy, Done and Product go to 0 immediately. After release, 5×5 gives Product=25.
